// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the E-stage multi-cycle divider:
//   - default operand width and iteration-counter width
//   - divider FSM state encoding
//   - MIPS funct codes that select DIV / DIVU in the ALU decoder
// -----------------------------------------------------------------------------
package div_unit_pkg;

    // Operand width; quotient and remainder are each this wide.
    localparam int DIV_WIDTH = 32;
    // Iteration counter width; 2**DIV_CNT_W must exceed DIV_WIDTH.
    localparam int DIV_CNT_W = 6;

    // MIPS R-type funct codes routed to this unit.
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step.
//   rem_i          partial remainder entering the step (always < divisor_i)
//   dividend_bit_i next dividend bit shifted into the partial remainder
//   divisor_i      divisor magnitude
//   rem_o          partial remainder after the step
//   quot_bit_o     quotient bit produced by the step (inverse of the borrow)
// -----------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;
    // Because rem_i < divisor_i, a non-negative difference always fits in
    // WIDTH bits, so the top difference bit carries no information.
    logic           diff_msb_unused;

    always_comb begin
        shifted         = {rem_i, dividend_bit_i};
        {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor_i};
        diff_msb_unused = diff[WIDTH];
        quot_bit_o      = ~borrow;
        // Restore (keep the shifted value) when the subtraction went negative.
        rem_o           = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the E stage.
// Ports:
//   clk         pipeline clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       E-stage holds a live DIV/DIVU (held high while stalled)
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   opdata1     dividend
//   opdata2     divisor
//   annul       cancel the in-flight divide (E flush / exception)
//   result      {remainder (HI), quotient (LO)}, holds until next completion
//   ready       one-cycle pulse when result is freshly valid
//   div_stall   to hazard unit: hold F/D/E while a divide is in flight
// Timing: start seen at cycle t -> div_stall for t..t+WIDTH, ready at
// t+WIDTH+1. Divide by zero -> div_stall for t..t+1, ready at t+2.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_stall
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e             state_q,    state_d;
    logic [WIDTH-1:0]       dividend_q, dividend_d;  // shifts out MSB first
    logic [WIDTH-1:0]       divisor_q,  divisor_d;
    logic [WIDTH-1:0]       rem_q,      rem_d;
    logic [WIDTH-1:0]       quot_q,     quot_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q,  neg_rem_d;
    logic [2*WIDTH-1:0]     result_q,   result_d;
    logic                   ready_q,    ready_d;

    // Operand magnitudes and sign flags (sign only meaningful for DIV).
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       abs_a, abs_b;

    // Single shared restoring step, iterated once per DIV_ON cycle.
    logic [WIDTH-1:0]       step_rem;
    logic                   step_qbit;
    logic [WIDTH-1:0]       quot_next;

    div_step #(
        .WIDTH          (WIDTH)
    ) u_div_step (
        .rem_i          (rem_q),
        .dividend_bit_i (dividend_q[WIDTH-1]),
        .divisor_i      (divisor_q),
        .rem_o          (step_rem),
        .quot_bit_o     (step_qbit)
    );

    always_comb begin
        a_neg     = signed_div & opdata1[WIDTH-1];
        b_neg     = signed_div & opdata2[WIDTH-1];
        // The most negative value negates to itself, which read as unsigned is
        // exactly its magnitude, so 0x80000000 / -1 wraps without special case.
        abs_a     = a_neg ? -opdata1 : opdata1;
        abs_b     = b_neg ? -opdata2 : opdata2;
        quot_next = {quot_q[WIDTH-2:0], step_qbit};
    end

    // NOTE: every signal assigned in this block gets a default first so that
    // no path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    dividend_d = abs_a;
                    divisor_d  = abs_b;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    state_d    = (opdata2 == '0) ? DIV_ZERO : DIV_ON;
                end
            end

            DIV_ZERO: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    result_d = {dividend_q, {WIDTH{1'b1}}};
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d      = step_rem;
                    quot_d     = quot_next;
                    dividend_d = dividend_q << 1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        // Sign fix-up folded into the final step: quotient
                        // negated on differing signs, remainder follows dividend.
                        result_d = {neg_rem_q  ? -step_rem  : step_rem,
                                    neg_quot_q ? -quot_next : quot_next};
                        ready_d  = 1'b1;
                        state_d  = DIV_END;
                    end
                end
            end

            DIV_END: begin
                // start is deliberately ignored here: the stalled instruction
                // is still in E this cycle and must not retrigger.
                state_d = DIV_IDLE;
            end

            default: state_d = DIV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Stall is combinational so the hazard unit freezes E in the very cycle a
    // divide is first seen. It is forced low while reset is asserted even if
    // start is still high.
    always_comb begin
        div_stall = 1'b0;
        unique case (state_q)
            DIV_IDLE: div_stall = start & ~annul;
            DIV_ZERO: div_stall = 1'b1;
            DIV_ON:   div_stall = 1'b1;
            DIV_END:  div_stall = 1'b0;
            default:  div_stall = 1'b0;
        endcase
        div_stall = div_stall & rst_n;
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit: unsigned and signed divides,
// divide by zero, held start across DIV_END, annul in DIV_ON and in IDLE,
// and asynchronous reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           div_stall;

    int n_cmp = 0;
    int n_err = 0;

    div_unit #(
        .WIDTH      (W),
        .CNT_W      (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .div_stall  (div_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance cycle by cycle until ready, with a cycle budget. Returns the
    // number of edges taken and whether div_stall stayed high before ready.
    task automatic wait_ready(output int cyc, output bit stall_ok);
        cyc      = 0;
        stall_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            cyc++;
            if (ready) break;
            if (!div_stall) stall_ok = 1'b0;
        end
    endtask

    // Launch one divide at the start of an IDLE cycle and check latency,
    // stall window, result and the single-cycle ready pulse.
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit hold, input logic [63:0] exp, input int lat);
        int cyc;
        bit stall_ok;
        @(posedge clk); #1;
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        #1;
        check({tag, "_stall_t"}, 64'(div_stall), 64'd1);
        wait_ready(cyc, stall_ok);
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_stall_win"}, 64'(stall_ok), 64'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_end"}, 64'(div_stall), 64'd0);
        if (!hold) begin
            start = 1'b0;
            @(posedge clk); #2;
            check({tag, "_pulse"}, 64'(ready), 64'd0);
        end
    endtask

    initial begin
        int  cyc;
        bit  stall_ok;
        bit  seen_ready;
        bit  seen_stall;

        rst_n      = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;

        // Reset state, including stall suppression while start is high.
        #12;
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        start = 1'b1;
        #1;
        check("rst_stall_gated", 64'(div_stall), 64'd0);
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Unsigned and signed directed vectors.
        do_div("divu_100_7",  32'd100,        32'd7,          1'b0, 1'b0, 64'h00000002_0000000E, 33);
        do_div("div_m7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_div("div_7_m2",    32'd7,          32'hFFFFFFFE,   1'b1, 1'b0, 64'h00000001_FFFFFFFD, 33);
        do_div("div_min_m1",  32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, 64'h00000000_80000000, 33);
        do_div("divu_big_10", 32'hFFFFFFFF,   32'd10,         1'b0, 1'b0, 64'h00000005_19999999, 33);
        do_div("divu_raw",    32'hFFFFFFF9,   32'd2,          1'b0, 1'b0, 64'h00000001_7FFFFFFC, 33);
        do_div("divu_5_9",    32'd5,          32'd9,          1'b0, 1'b0, 64'h00000005_00000000, 33);
        do_div("divu_zero",   32'h00001234,   32'd0,          1'b0, 1'b0, 64'h00001234_FFFFFFFF, 2);

        // Held start: start stays high through DIV_END and into the next IDLE
        // cycle with fresh operands 9/3.
        do_div("held_50_5",   32'd50,         32'd5,          1'b0, 1'b1, 64'h00000000_0000000A, 33);
        opdata1 = 32'd9;
        opdata2 = 32'd3;
        @(posedge clk); #2;
        check("held_pulse", 64'(ready), 64'd0);
        check("held_restart_stall", 64'(div_stall), 64'd1);
        wait_ready(cyc, stall_ok);
        check("held_latency", 64'(cyc), 64'd33);
        check("held_stall_win", 64'(stall_ok), 64'd1);
        check("held_result", result, 64'h00000000_00000003);
        start = 1'b0;
        @(posedge clk); #2;
        check("held_pulse2", 64'(ready), 64'd0);

        // annul at t+10 of a divide.
        @(posedge clk); #1;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        check("annul_stall_t10", 64'(div_stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("annul_stall_t11", 64'(div_stall), 64'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            seen_ready |= ready;
        end
        check("annul_no_ready", 64'(seen_ready), 64'd0);
        check("annul_result_held", result, 64'h00000000_00000003);

        // annul together with start in IDLE does not begin a divide.
        @(posedge clk); #1;
        start = 1'b1;
        annul = 1'b1;
        #1;
        check("idle_annul_stall", 64'(div_stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        annul = 1'b0;
        #1;
        check("idle_annul_state", 64'(div_stall), 64'd0);
        seen_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            seen_ready |= ready;
        end
        check("idle_annul_no_ready", 64'(seen_ready), 64'd0);

        // Asynchronous reset between clock edges in the middle of DIV_ON.
        @(posedge clk); #1;
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(div_stall), 64'd0);
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        seen_ready = 1'b0;
        seen_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            seen_ready |= ready;
            seen_stall |= div_stall;
        end
        check("arst_no_ready", 64'(seen_ready), 64'd0);
        check("arst_no_stall", 64'(seen_stall), 64'd0);
        check("arst_result_idle", result, 64'd0);

        // Recovery after reset.
        do_div("post_rst", 32'd100, 32'd7, 1'b0, 1'b0, 64'h00000002_0000000E, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_div_unit
